// File: rtl/riscv_test_monitor_if.sv
// riscv_test_monitor_if: signal bundle between the simulation top (master) and the
// end-of-test monitor (slave).
//   i_retire / i_pc                      retire strobe and PC of the retiring instruction
//   i_mem_we / i_mem_addr / i_mem_wdata  data-memory write port being snooped
//   i_trace_idx                          PC history read index, 0 = newest
//   o_done / o_pass / o_status           verdict
//   o_fail_code                          failing test number or HUNG/TIMEOUT tag
//   o_cycle_cnt / o_retired              run-time counters
//   o_trace_pc / o_trace_cnt             PC history read data and valid entry count
interface riscv_test_monitor_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TRACE_DEPTH = 8
);
    localparam int unsigned IdxW = $clog2(TRACE_DEPTH);

    logic            i_retire;
    logic [XLEN-1:0] i_pc;
    logic            i_mem_we;
    logic [XLEN-1:0] i_mem_addr;
    logic [XLEN-1:0] i_mem_wdata;
    logic [IdxW-1:0] i_trace_idx;
    logic            o_done;
    logic            o_pass;
    logic [1:0]      o_status;
    logic [XLEN-1:0] o_fail_code;
    logic [XLEN-1:0] o_cycle_cnt;
    logic [XLEN-1:0] o_retired;
    logic [XLEN-1:0] o_trace_pc;
    logic [IdxW:0]   o_trace_cnt;

    modport master (
        output i_retire, i_pc, i_mem_we, i_mem_addr, i_mem_wdata, i_trace_idx,
        input  o_done, o_pass, o_status, o_fail_code, o_cycle_cnt, o_retired,
               o_trace_pc, o_trace_cnt
    );

    modport slave (
        input  i_retire, i_pc, i_mem_we, i_mem_addr, i_mem_wdata, i_trace_idx,
        output o_done, o_pass, o_status, o_fail_code, o_cycle_cnt, o_retired,
               o_trace_pc, o_trace_cnt
    );
endinterface

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: end-of-test monitor using the riscv-tests tohost convention.
// Watches retires and data-memory writes and settles on PASS, FAIL, HUNG (same PC
// retired LOOP_DETECT times in a row) or TIMEOUT. Counts cycles and retires while
// running and keeps a ring buffer of recently retired PCs. Verdicts are sticky
// until reset.
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   mon    riscv_test_monitor_if slave modport (stimulus in, verdict/counters/trace out)
module riscv_test_monitor #(
    parameter int unsigned          XLEN           = 32,
    parameter logic [XLEN-1:0]      TOHOST_ADDR    = 32'h0000_1000,
    parameter int unsigned          TIMEOUT_CYCLES = 1000,
    parameter int unsigned          LOOP_DETECT    = 4,
    parameter int unsigned          TRACE_DEPTH    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    riscv_test_monitor_if.slave   mon
);
    localparam int unsigned PtrW = $clog2(TRACE_DEPTH);
    localparam logic [XLEN-1:0] HungCode    = 32'hDEAD_0001;
    localparam logic [XLEN-1:0] TimeoutCode = 32'hDEAD_0002;

    typedef enum logic [2:0] {StRun, StPass, StFail, StHung, StTimeout} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fail_code_q, fail_code_d;
    logic [XLEN-1:0] cycle_q, cycle_d;
    logic [XLEN-1:0] retired_q, retired_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic [31:0]     same_q, same_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   trace_cnt_q, trace_cnt_d;
    logic            trace_we;
    logic            tohost_hit;
    logic            loop_hit;
    logic [XLEN-1:0] trace_buf [TRACE_DEPTH];
    logic [PtrW-1:0] rd_ptr;

    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        cycle_d     = cycle_q;
        retired_d   = retired_q;
        last_pc_d   = last_pc_q;
        same_d      = same_q;
        wr_ptr_d    = wr_ptr_q;
        trace_cnt_d = trace_cnt_q;
        trace_we    = 1'b0;
        loop_hit    = 1'b0;
        tohost_hit  = mon.i_mem_we && (mon.i_mem_addr == TOHOST_ADDR);

        if (state_q == StRun) begin
            cycle_d = cycle_q + 1'b1;
            if (mon.i_retire) begin
                retired_d = retired_q + 1'b1;
                trace_we  = 1'b1;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                if (trace_cnt_q != (PtrW+1)'(TRACE_DEPTH)) begin
                    trace_cnt_d = trace_cnt_q + 1'b1;
                end
                last_pc_d = mon.i_pc;
                // After reset same_q is 0, so the first retire lands on 1 either way.
                same_d    = (mon.i_pc == last_pc_q) ? same_q + 1 : 32'd1;
                loop_hit  = (same_d == LOOP_DETECT);
            end

            // Priority: tohost verdict, then loop, then timeout. Even tohost
            // values are console traffic and do not block lower-priority events.
            if (tohost_hit && mon.i_mem_wdata == XLEN'(1)) begin
                state_d = StPass;
            end else if (tohost_hit && mon.i_mem_wdata[0]) begin
                state_d     = StFail;
                fail_code_d = mon.i_mem_wdata >> 1;
            end else if (loop_hit) begin
                state_d     = StHung;
                fail_code_d = HungCode;
            end else if (cycle_q == XLEN'(TIMEOUT_CYCLES - 1)) begin
                state_d     = StTimeout;
                fail_code_d = TimeoutCode;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StRun;
            fail_code_q <= '0;
            cycle_q     <= '0;
            retired_q   <= '0;
            last_pc_q   <= '0;
            same_q      <= '0;
            wr_ptr_q    <= '0;
            trace_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
            cycle_q     <= cycle_d;
            retired_q   <= retired_d;
            last_pc_q   <= last_pc_d;
            same_q      <= same_d;
            wr_ptr_q    <= wr_ptr_d;
            trace_cnt_q <= trace_cnt_d;
        end
    end

    // Storage is left unreset; stale entries are masked by trace_cnt_q on read.
    always_ff @(posedge i_clk) begin
        if (trace_we && !i_rst) begin
            trace_buf[wr_ptr_q] <= mon.i_pc;
        end
    end

    assign rd_ptr = wr_ptr_q - PtrW'(1) - mon.i_trace_idx;

    always_comb begin
        mon.o_done      = (state_q != StRun);
        mon.o_pass      = (state_q == StPass);
        mon.o_fail_code = fail_code_q;
        mon.o_cycle_cnt = cycle_q;
        mon.o_retired   = retired_q;
        mon.o_trace_cnt = trace_cnt_q;
        mon.o_trace_pc  = ({1'b0, mon.i_trace_idx} < trace_cnt_q) ? trace_buf[rd_ptr] : '0;
        mon.o_status    = 2'd0;
        unique case (state_q)
            StRun:               mon.o_status = 2'd0;
            StPass:              mon.o_status = 2'd1;
            StFail:              mon.o_status = 2'd2;
            StHung, StTimeout:   mon.o_status = 2'd3;
            default:             mon.o_status = 2'd0;
        endcase
    end
endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench: dut_a uses the default 1000-cycle timeout, dut_t a 10-cycle
// timeout; both see the same stimulus and are checked in the tests that concern them.
module tb_riscv_test_monitor;
    localparam logic [31:0] Tohost = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        retire = 1'b0;
    logic [31:0] pc = '0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  tidx = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    riscv_test_monitor_if #(.XLEN(32), .TRACE_DEPTH(8)) bus_a ();
    riscv_test_monitor_if #(.XLEN(32), .TRACE_DEPTH(8)) bus_t ();

    assign bus_a.i_retire = retire;
    assign bus_a.i_pc = pc;
    assign bus_a.i_mem_we = we;
    assign bus_a.i_mem_addr = addr;
    assign bus_a.i_mem_wdata = wdata;
    assign bus_a.i_trace_idx = tidx;
    assign bus_t.i_retire = retire;
    assign bus_t.i_pc = pc;
    assign bus_t.i_mem_we = we;
    assign bus_t.i_mem_addr = addr;
    assign bus_t.i_mem_wdata = wdata;
    assign bus_t.i_trace_idx = tidx;

    riscv_test_monitor #(
        .XLEN(32), .TOHOST_ADDR(Tohost), .TIMEOUT_CYCLES(1000), .LOOP_DETECT(4), .TRACE_DEPTH(8)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .mon(bus_a.slave)
    );

    riscv_test_monitor #(
        .XLEN(32), .TOHOST_ADDR(Tohost), .TIMEOUT_CYCLES(10), .LOOP_DETECT(4), .TRACE_DEPTH(8)
    ) dut_t (
        .i_clk(clk), .i_rst(rst), .mon(bus_t.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic r, input logic [31:0] p, input logic w,
                        input logic [31:0] wd);
        retire = r;
        pc     = p;
        we     = w;
        addr   = w ? Tohost : 32'h0;
        wdata  = wd;
        @(posedge clk);
        #1;
        retire = 1'b0;
        we     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        check("rst_done", bus_a.o_done, 0);
        check("rst_status", bus_a.o_status, 0);
        check("rst_cycle", bus_a.o_cycle_cnt, 0);
        check("rst_trace_cnt", bus_a.o_trace_cnt, 0);
        do_reset();

        // 1: PASS after PCs 0,4,8 and tohost=1 on cycle 3
        step(1, 32'h0, 0, 0);
        step(1, 32'h4, 0, 0);
        step(1, 32'h8, 0, 0);
        check("t1_running", bus_a.o_done, 0);
        step(0, 32'h0, 1, 32'd1);
        check("t1_done", bus_a.o_done, 1);
        check("t1_pass", bus_a.o_pass, 1);
        check("t1_status", bus_a.o_status, 1);
        check("t1_cycle", bus_a.o_cycle_cnt, 4);
        check("t1_retired", bus_a.o_retired, 3);
        check("t1_code", bus_a.o_fail_code, 0);
        check("t1_tcnt", bus_a.o_trace_cnt, 3);
        tidx = 3'd0;
        #1 check("t1_idx0", bus_a.o_trace_pc, 32'h8);
        tidx = 3'd2;
        #1 check("t1_idx2", bus_a.o_trace_pc, 32'h0);
        tidx = 3'd3;
        #1 check("t1_idx3_empty", bus_a.o_trace_pc, 32'h0);
        step(1, 32'h50, 1, 32'd7);
        check("t1_sticky_status", bus_a.o_status, 1);
        check("t1_frozen_cycle", bus_a.o_cycle_cnt, 4);
        check("t1_frozen_ret", bus_a.o_retired, 3);

        // 2: console write ignored, then FAIL with code 3
        do_reset();
        step(0, 32'h0, 1, 32'h40);
        check("t2_console_status", bus_a.o_status, 0);
        check("t2_console_done", bus_a.o_done, 0);
        step(0, 32'h0, 1, 32'h7);
        check("t2_status", bus_a.o_status, 2);
        check("t2_code", bus_a.o_fail_code, 3);
        check("t2_pass", bus_a.o_pass, 0);
        check("t2_done", bus_a.o_done, 1);

        // 3: HUNG on the fourth consecutive retire at 8
        do_reset();
        step(1, 32'h0, 0, 0);
        step(1, 32'h4, 0, 0);
        step(1, 32'h8, 0, 0);
        step(1, 32'h8, 0, 0);
        step(0, 32'h8, 0, 0);  // non-retire cycle holds the count
        step(1, 32'h8, 0, 0);
        check("t3_not_yet", bus_a.o_status, 0);
        step(1, 32'h8, 0, 0);
        check("t3_status", bus_a.o_status, 3);
        check("t3_code", bus_a.o_fail_code, 32'hDEAD_0001);
        check("t3_retired", bus_a.o_retired, 6);
        check("t3_cycle", bus_a.o_cycle_cnt, 7);

        // 4: TIMEOUT after 10 cycles on dut_t
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 32'h200 + 32'(4 * i), 0, 0);
        check("t4_not_yet", bus_t.o_done, 0);
        step(1, 32'h300, 0, 0);
        check("t4_status", bus_t.o_status, 3);
        check("t4_code", bus_t.o_fail_code, 32'hDEAD_0002);
        check("t4_cycle", bus_t.o_cycle_cnt, 10);
        check("t4_retired", bus_t.o_retired, 10);
        check("t4_pass", bus_t.o_pass, 0);
        step(1, 32'h304, 1, 32'd1);
        check("t4_sticky_code", bus_t.o_fail_code, 32'hDEAD_0002);
        check("t4_sticky_status", bus_t.o_status, 3);
        check("t4_frozen_cycle", bus_t.o_cycle_cnt, 10);

        // 5a: tohost=1 and loop threshold in the same cycle -> PASS
        do_reset();
        step(1, 32'h8, 0, 0);
        step(1, 32'h8, 0, 0);
        step(1, 32'h8, 0, 0);
        step(1, 32'h8, 1, 32'd1);
        check("t5a_status", bus_a.o_status, 1);
        check("t5a_retired", bus_a.o_retired, 4);
        check("t5a_code", bus_a.o_fail_code, 0);

        // 5b: tohost=1 on cycle TIMEOUT_CYCLES-1 -> PASS
        do_reset();
        for (int i = 0; i < 9; i++) step(0, 32'h0, 0, 0);
        step(0, 32'h0, 1, 32'd1);
        check("t5b_status", bus_t.o_status, 1);
        check("t5b_pass", bus_t.o_pass, 1);
        check("t5b_cycle", bus_t.o_cycle_cnt, 10);

        // 6: ring buffer wrap, then mid-run reset
        do_reset();
        for (int i = 0; i < 11; i++) step(1, 32'h100 + 32'(4 * i), 0, 0);
        check("t6_tcnt", bus_a.o_trace_cnt, 8);
        tidx = 3'd0;
        #1 check("t6_idx0", bus_a.o_trace_pc, 32'h128);
        tidx = 3'd3;
        #1 check("t6_idx3", bus_a.o_trace_pc, 32'h11C);
        tidx = 3'd7;
        #1 check("t6_idx7", bus_a.o_trace_pc, 32'h10C);
        check("t6_retired", bus_a.o_retired, 11);
        rst = 1'b1;
        #1;
        check("t6_rst_tcnt", bus_a.o_trace_cnt, 0);
        check("t6_rst_pc", bus_a.o_trace_pc, 0);
        check("t6_rst_cycle", bus_a.o_cycle_cnt, 0);
        check("t6_rst_retired", bus_a.o_retired, 0);
        check("t6_rst_status", bus_a.o_status, 0);
        check("t6_rst_t_done", bus_t.o_done, 0);
        check("t6_rst_t_code", bus_t.o_fail_code, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
